key_rewind: RTL

KEY_REWIND -- requirements
Module: key_rewind

---
 rtl/key_rewind.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/key_rewind.sv
// rtl/key_rewind.sv - AES-128 key schedule walked backwards from the round-10 key
//
// key_rewind: takes the round-10 key and emits round keys 9 down to 0, one per
// accepted handshake, then pulses po_done.
//   pi_clk        clock, all state on the rising edge
//   pi_rst_n      asynchronous active-low reset
//   pi_start      begin a rewind from pi_last_key (honoured only in IDLE)
//   pi_last_key   round-10 key, row-major key-bus layout
//   pi_ready      consumer accepts po_round_key this cycle
//   po_busy       high while a rewind is in progress
//   po_valid      po_round_key / po_round_idx are valid
//   po_round_key  recovered round key, same layout as pi_last_key
//   po_round_idx  round number of po_round_key (9..0)
//   po_done       one-cycle pulse after the round-0 key is accepted
//
// key_rewind_sbox: combinational AES forward S-box
//   din   input byte
//   dout  substituted byte

module key_rewind_sbox (
    input  logic [7:0] din,
    output logic [7:0] dout
);
    localparam logic [2047:0] SBOX_TABLE = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    // Entry x occupies bits [8*(255-x)+7 -: 8]; {~x, 3'b111} is that MSB index.
    assign dout = SBOX_TABLE[{~din, 3'b111} -: 8];
endmodule

module key_rewind (
    input  logic         pi_clk,
    input  logic         pi_rst_n,
    input  logic         pi_start,
    input  logic [127:0] pi_last_key,
    input  logic         pi_ready,
    output logic         po_busy,
    output logic         po_valid,
    output logic [127:0] po_round_key,
    output logic [3:0]   po_round_idx,
    output logic         po_done
);
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    state_t       state;
    logic [127:0] key_reg;
    logic [3:0]   idx;
    logic [7:0]   rcon;
    logic         done_reg;

    logic [127:0] step_in;
    logic [127:0] step_out;
    logic [31:0]  n0, n1, n2, n3;
    logic [31:0]  w0, w1, w2, w3;
    logic [31:0]  rot_w3;
    logic [31:0]  sub_w3;

    // Column c of the row-major bus, row 0 in the top byte.
    function automatic logic [31:0] get_word(input logic [127:0] bus, input int c);
        get_word = {bus[127-8*c -: 8], bus[95-8*c -: 8], bus[63-8*c -: 8], bus[31-8*c -: 8]};
    endfunction

    function automatic logic [127:0] put_words(input logic [31:0] a, input logic [31:0] b,
                                               input logic [31:0] c, input logic [31:0] d);
        put_words = {a[31:24], b[31:24], c[31:24], d[31:24],
                     a[23:16], b[23:16], c[23:16], d[23:16],
                     a[15:8],  b[15:8],  c[15:8],  d[15:8],
                     a[7:0],   b[7:0],   c[7:0],   d[7:0]};
    endfunction

    // Inverse of the forward xtime doubling: halve in GF(2^8).
    function automatic logic [7:0] rcon_next(input logic [7:0] rc);
        if (rc[0])
            rcon_next = ((rc ^ 8'h1B) >> 1) | 8'h80;
        else
            rcon_next = rc >> 1;
    endfunction

    // In IDLE the step works on the incoming key so the first result is ready
    // straight after the start edge; in RUN it works on the held key.
    assign step_in = (state == IDLE) ? pi_last_key : key_reg;

    assign n0 = get_word(step_in, 0);
    assign n1 = get_word(step_in, 1);
    assign n2 = get_word(step_in, 2);
    assign n3 = get_word(step_in, 3);

    assign w3     = n3 ^ n2;
    assign w2     = n2 ^ n1;
    assign w1     = n1 ^ n0;
    assign rot_w3 = {w3[23:0], w3[31:24]};

    key_rewind_sbox u_sbox0 (.din(rot_w3[31:24]), .dout(sub_w3[31:24]));
    key_rewind_sbox u_sbox1 (.din(rot_w3[23:16]), .dout(sub_w3[23:16]));
    key_rewind_sbox u_sbox2 (.din(rot_w3[15:8]),  .dout(sub_w3[15:8]));
    key_rewind_sbox u_sbox3 (.din(rot_w3[7:0]),   .dout(sub_w3[7:0]));

    assign w0       = n0 ^ sub_w3 ^ {rcon, 24'h0};
    assign step_out = put_words(w0, w1, w2, w3);

    always_ff @(posedge pi_clk or negedge pi_rst_n) begin
        if (!pi_rst_n) begin
            state    <= IDLE;
            key_reg  <= '0;
            idx      <= '0;
            rcon     <= 8'h36;
            done_reg <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            case (state)
                IDLE: begin
                    // A start seen alongside the done pulse is dropped.
                    if (pi_start && !done_reg) begin
                        key_reg <= step_out;
                        idx     <= 4'd9;
                        rcon    <= 8'h1B;
                        state   <= RUN;
                    end
                end
                RUN: begin
                    if (pi_ready) begin
                        if (idx != 4'd0) begin
                            key_reg <= step_out;
                            idx     <= idx - 4'd1;
                            rcon    <= rcon_next(rcon);
                        end else begin
                            state    <= IDLE;
                            done_reg <= 1'b1;
                            rcon     <= 8'h36;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign po_busy      = (state == RUN);
    assign po_valid     = (state == RUN);
    assign po_round_key = key_reg;
    assign po_round_idx = idx;
    assign po_done      = done_reg;
endmodule
